// File: rtl/dcache_wb_buffer.sv
// Write-back buffer: queues dirty lines evicted by the data cache and drains them to memory
// over a req/ack handshake. A combinational lookup port exposes queued lines to the refill
// path. A write to a line that is queued but not yet in flight is merged into that entry.
module dcache_wb_buffer #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned LINE_W = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wb_req_i,
    input  logic [ADDR_W-1:0] wb_addr_i,
    input  logic [LINE_W-1:0] wb_data_i,
    output logic              wb_ack_o,
    input  logic [ADDR_W-1:0] lkup_addr_i,
    output logic              lkup_hit_o,
    output logic [LINE_W-1:0] lkup_data_o,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [LINE_W-1:0] mem_data_o,
    input  logic              mem_ack_i,
    output logic              empty_o,
    output logic              full_o
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned TAG_W = ADDR_W - 4;
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    typedef enum logic {StIdle, StReq} state_e;

    state_e            state_q, state_d;
    logic [DEPTH-1:0]  valid_q;
    logic [TAG_W-1:0]  tag_q  [DEPTH];
    logic [LINE_W-1:0] data_q [DEPTH];
    logic [PTR_W-1:0]  head_q, tail_q;
    logic [PTR_W:0]    count_q;

    logic [TAG_W-1:0]  wb_tag, lk_tag;
    logic              coal_hit, lk_hit;
    logic [PTR_W-1:0]  coal_idx, lk_idx;
    logic              is_full, enq, pop, in_flight;
    logic              unused_addr_bits;

    assign wb_tag    = wb_addr_i[ADDR_W-1:4];
    assign lk_tag    = lkup_addr_i[ADDR_W-1:4];
    assign is_full   = (count_q == FULL_CNT);
    assign in_flight = (state_q == StReq);
    assign enq       = wb_req_i && !coal_hit && !is_full;
    assign pop       = in_flight && mem_ack_i;

    // Byte-offset bits are don't-care for a line address.
    assign unused_addr_bits = ^{wb_addr_i[3:0], lkup_addr_i[3:0]};

    // Merge target: any valid match except the head while it is being written to memory.
    always_comb begin
        coal_hit = 1'b0;
        coal_idx = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (tag_q[i] == wb_tag) &&
                !(in_flight && (PTR_W'(i) == head_q))) begin
                coal_hit = 1'b1;
                coal_idx = PTR_W'(i);
            end
        end
    end

    // Lookup: a non-head match is always the younger copy, so it wins over the head.
    always_comb begin
        lk_hit = 1'b0;
        lk_idx = head_q;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (tag_q[i] == lk_tag) && (PTR_W'(i) != head_q)) begin
                lk_hit = 1'b1;
                lk_idx = PTR_W'(i);
            end
        end
        if (!lk_hit && valid_q[head_q] && (tag_q[head_q] == lk_tag)) begin
            lk_hit = 1'b1;
        end
    end

    // Drain FSM next state: one idle bubble between consecutive memory writes.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (count_q != '0) state_d = StReq;
            StReq:   if (mem_ack_i) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Drain FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    // Entry storage, pointers and occupancy count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            if (wb_req_i && coal_hit) begin
                data_q[coal_idx] <= wb_data_i;
            end
            if (enq) begin
                valid_q[tail_q] <= 1'b1;
                tag_q[tail_q]   <= wb_tag;
                data_q[tail_q]  <= wb_data_i;
                tail_q          <= tail_q + 1'b1;
            end
            if (pop) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + 1'b1;
            end
            case ({enq, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Outputs are forced to their idle values while reset is held.
    assign wb_ack_o    = rst_n && wb_req_i && (coal_hit || !is_full);
    assign lkup_hit_o  = rst_n && lk_hit;
    assign lkup_data_o = (rst_n && lk_hit) ? data_q[lk_idx] : '0;
    assign mem_req_o   = rst_n && in_flight;
    assign mem_addr_o  = rst_n ? {tag_q[head_q], 4'b0000} : '0;
    assign mem_data_o  = rst_n ? data_q[head_q] : '0;
    assign empty_o     = !rst_n || (count_q == '0);
    assign full_o      = rst_n && is_full;

endmodule

// File: doc/dcache_wb_buffer.md
# dcache_wb_buffer

Write-back buffer between the data-cache datapath and the data-memory interface. It accepts dirty 128-bit lines evicted by the cache controller, queues them in a small FIFO and drains them to memory with a req/ack handshake, so the refill of the missing line does not wait behind the writeback. A combinational lookup port lets the controller detect, and take data from, a line that is still waiting in the buffer. Writes to a line already queued and not yet in flight are coalesced into that entry.

## Interface
Parameters:
- DEPTH, 4, number of line entries; power of two, ≥2
- ADDR_W, 32, byte-address width
- LINE_W, 128, line width in bits (16 bytes; offset bits = 4)

Ports:
- Clock and reset: clock clk; reset rst_n, synchronous, active-low.
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- wb_req_i  in  1  enqueue request from the cache controller
- wb_addr_i  in  ADDR_W  line address of the evicted line; bits [3:0] ignored
- wb_data_i  in  LINE_W  evicted line data
- wb_ack_o  out  1  combinational; request accepted this cycle
- lkup_addr_i  in  ADDR_W  miss address to check against the buffer
- lkup_hit_o  out  1  combinational; a valid entry matches lkup_addr_i[ADDR_W-1:4]
- lkup_data_o  out  LINE_W  data of the youngest matching entry; 0 when there is no hit
- mem_req_o  out  1  write request to memory (registered)
- mem_addr_o  out  ADDR_W  head line address, bits [3:0] = 0
- mem_data_o  out  LINE_W  head line data
- mem_ack_i  in  1  memory accepted the head write
- empty_o  out  1  count == 0
- full_o  out  1  count == DEPTH

## Operation
- Storage: DEPTH entries of {valid, line addr [ADDR_W-1:4], data}. Head and tail pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits.
- Coalesce: if wb_req_i is high and a valid entry matches wb_addr_i[ADDR_W-1:4], and that entry is not the head while state == REQ:
  - overwrite that entry's data
  - wb_ack_o = 1; count unchanged.
- Enqueue: otherwise, wb_ack_o = (count < DEPTH). On accept, write the entry at tail, then tail++ and count++.
- A request rejected while full must be held by the controller until wb_ack_o is high.
- Drain FSM, two states:
  - IDLE: if count != 0, go to REQ.
  - REQ: mem_req_o = 1, with addr/data taken from the head entry. On mem_ack_i: clear the head entry's valid bit, head++, count--, go to IDLE.
- Head addr/data must stay stable for the whole time REQ is held, because coalescing into the in-flight head is blocked.
- Lookup: compare lkup_addr_i[ADDR_W-1:4] against all valid entries. Two matches are possible only when one of them is the in-flight head. In that case return the younger entry: the non-head one.
- Simultaneous enqueue and pop: both take effect, so count is unchanged. Accept is decided on count at the start of the cycle, so a full buffer rejects even when a pop happens in the same cycle.
- mem_ack_i is ignored in IDLE.
- Reset: all valid bits 0, head = tail = 0, count = 0, state IDLE.
- Output values during reset: mem_req_o = 0, wb_ack_o = 0, lkup_hit_o = 0, empty_o = 1, full_o = 0, mem_addr_o = 0, mem_data_o = 0, lkup_data_o = 0.
- Reset asserted mid-transaction drops all entries, including an unacknowledged in-flight line.

## Timing
- Enqueue is accepted in the cycle wb_req_i && wb_ack_o; the entry is visible (count, lookup) from the next cycle.
- An entry accepted at edge k into an empty buffer: state becomes REQ at edge k+1, and mem_req_o is high from the cycle after edge k+1.
- mem_req_o stays high until the edge where mem_ack_i = 1. The entry is popped at that edge, and mem_req_o is low the following cycle.
- There is one IDLE bubble between consecutive memory writes, so drain throughput is 1 line per 2 cycles plus memory latency.
- Lookup has zero-cycle latency and is combinational from lkup_addr_i and the current storage state. An entry popped at edge k is not a hit after edge k.

## Test plan
- Reset, then idle: empty_o = 1, mem_req_o = 0, lkup_hit_o = 0 for lkup_addr_i = 0x1000.
- Enqueue 0x1000/D0 into an empty buffer with mem_ack_i held 0:
  - mem_req_o rises 2 cycles after the accept
  - mem_addr_o = 0x1000, mem_data_o = D0
  - ack after 3 cycles → empty_o = 1 the next cycle.
- Fill 4 lines (0x100, 0x200, 0x300, 0x400) with memory stalled:
  - full_o = 1; a fifth request for 0x500 gets wb_ack_o = 0
  - one ack → 0x500 is accepted the following cycle
  - drain order is 0x100, 0x200, 0x300, 0x400, 0x500.
- Coalesce: with memory stalled and 0x100 in flight, enqueue 0x200/A then 0x20C/B:
  - count = 2, and lookup of 0x208 returns B
  - enqueue 0x104/C → a new entry, count = 3; lookup of 0x100 returns C; memory still receives the original data for 0x100 first.
- Simultaneous enqueue and ack at count = 2 → count stays 2, and the pointers wrap correctly over 10 such cycles.
- Assert rst_n = 0 while mem_req_o = 1 with 3 entries queued → the next cycle shows empty_o = 1, mem_req_o = 0, lkup_hit_o = 0.
